// File: rtl/window_deserializer.sv
// ---------------------------------------------------------------------------
// window_deserializer
//
// Rebuilds one WINDOW_WIDTH-bit HOG detection window and its pyramid-level tag
// from a BUS_WIDTH-wide beat stream: one header beat, then BEATS payload
// beats, lowest chunk first. The finished window sits in a valid/ready output
// register. A second window can wait in the assembly register, so one window
// of skid buffering is available.
//
// Ports
//   clk           single clock (clk_140 domain)
//   rst           asynchronous, active-high reset
//   stream        incoming beat
//   stream_valid  beat valid
//   stream_ready  beat is accepted when stream_valid & stream_ready
//   window        reassembled window
//   metadata      level tag taken from the header beat
//   window_valid  window/metadata valid
//   window_ready  consumer accepts the window
//   frame_err     one-cycle pulse after a header beat with a bad SYNC marker
//
// Handshakes: a beat or window moves on a rising clk edge where valid and
// ready are both high. A producer holding valid must keep its data stable
// until that edge. window/metadata stay unchanged while
// window_valid & ~window_ready.
// ---------------------------------------------------------------------------
module window_deserializer #(
    parameter int          WINDOW_WIDTH = 1152,
    parameter int          BUS_WIDTH    = 128,
    parameter int          META_WIDTH   = 3,
    parameter logic [7:0]  SYNC         = 8'hA5
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [BUS_WIDTH-1:0]    stream,
    input  logic                    stream_valid,
    output logic                    stream_ready,
    output logic [WINDOW_WIDTH-1:0] window,
    output logic [META_WIDTH-1:0]   metadata,
    output logic                    window_valid,
    input  logic                    window_ready,
    output logic                    frame_err
);

    localparam int BEATS = (WINDOW_WIDTH + BUS_WIDTH - 1) / BUS_WIDTH;
    localparam int CNT_W = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int ASM_W = BEATS * BUS_WIDTH;
    localparam logic [CNT_W-1:0] LAST_BEAT = CNT_W'(BEATS - 1);

    localparam logic [1:0] ST_HDR  = 2'd0;
    localparam logic [1:0] ST_PAY  = 2'd1;
    localparam logic [1:0] ST_HOLD = 2'd2;

    logic [1:0]              state_q,     state_d;
    logic [CNT_W-1:0]        beat_cnt_q,  beat_cnt_d;
    logic [ASM_W-1:0]        asm_q,       asm_d;
    logic [META_WIDTH-1:0]   asm_meta_q,  asm_meta_d;
    logic [WINDOW_WIDTH-1:0] win_q,       win_d;
    logic [META_WIDTH-1:0]   meta_q,      meta_d;
    logic                    win_valid_q, win_valid_d;
    logic                    frame_err_q, frame_err_d;

    logic accept;
    logic out_free;

    assign stream_ready = ~rst & (state_q != ST_HOLD);
    assign accept       = stream_valid & stream_ready;
    // The output register may take a new window when it is empty or is
    // being emptied on this very edge.
    assign out_free     = ~win_valid_q | window_ready;

    always_comb begin
        state_d     = state_q;
        beat_cnt_d  = beat_cnt_q;
        asm_d       = asm_q;
        asm_meta_d  = asm_meta_q;
        win_d       = win_q;
        meta_d      = meta_q;
        // A handshake empties the output. A load later in this block sets
        // valid again, so a handshake and a reload in one cycle keep it high.
        win_valid_d = win_valid_q & ~window_ready;
        frame_err_d = 1'b0;

        case (state_q)
            ST_HDR: begin
                if (accept) begin
                    if (stream[BUS_WIDTH-1 -: 8] == SYNC) begin
                        asm_meta_d = stream[META_WIDTH-1:0];
                        beat_cnt_d = '0;
                        state_d    = ST_PAY;
                    end else begin
                        frame_err_d = 1'b1;
                    end
                end
            end

            ST_PAY: begin
                if (accept) begin
                    for (int k = 0; k < BEATS; k++) begin
                        if (beat_cnt_q == CNT_W'(k)) begin
                            asm_d[k*BUS_WIDTH +: BUS_WIDTH] = stream;
                        end
                    end
                    if (beat_cnt_q == LAST_BEAT) begin
                        beat_cnt_d = '0;
                        if (out_free) begin
                            // Bypass: the window goes out complete with this beat.
                            win_d       = asm_d[WINDOW_WIDTH-1:0];
                            meta_d      = asm_meta_d;
                            win_valid_d = 1'b1;
                            state_d     = ST_HDR;
                        end else begin
                            state_d = ST_HOLD;
                        end
                    end else begin
                        beat_cnt_d = beat_cnt_q + 1'b1;
                    end
                end
            end

            ST_HOLD: begin
                if (out_free) begin
                    win_d       = asm_q[WINDOW_WIDTH-1:0];
                    meta_d      = asm_meta_q;
                    win_valid_d = 1'b1;
                    state_d     = ST_HDR;
                end
            end

            default: begin
                state_d    = ST_HDR;
                beat_cnt_d = '0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_HDR;
            beat_cnt_q  <= '0;
            asm_q       <= '0;
            asm_meta_q  <= '0;
            win_q       <= '0;
            meta_q      <= '0;
            win_valid_q <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            beat_cnt_q  <= beat_cnt_d;
            asm_q       <= asm_d;
            asm_meta_q  <= asm_meta_d;
            win_q       <= win_d;
            meta_q      <= meta_d;
            win_valid_q <= win_valid_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign window       = win_q;
    assign metadata     = meta_q;
    assign window_valid = win_valid_q;
    assign frame_err    = frame_err_q;

endmodule

// File: tb/tb_window_deserializer.sv
// ---------------------------------------------------------------------------
// Bench for window_deserializer at default parameters. The drivers send whole
// frames. Each completed frame pushes {metadata, window} onto exp_q. One
// process compares the DUT against that queue on every falling edge. It also
// checks frame_err against the header beats the drivers marked as bad.
// ---------------------------------------------------------------------------
module tb_window_deserializer;

    localparam int WW = 1152;
    localparam int BW = 128;
    localparam int MW = 3;
    localparam int NB = 9;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [BW-1:0] stream = '0;
    logic          stream_valid = 1'b0;
    logic          stream_ready;
    logic [WW-1:0] window;
    logic [MW-1:0] metadata;
    logic          window_valid;
    logic          window_ready = 1'b1;
    logic          frame_err;

    window_deserializer #(
        .WINDOW_WIDTH(WW), .BUS_WIDTH(BW), .META_WIDTH(MW), .SYNC(8'hA5)
    ) dut (
        .clk(clk), .rst(rst), .stream(stream), .stream_valid(stream_valid),
        .stream_ready(stream_ready), .window(window), .metadata(metadata),
        .window_valid(window_valid), .window_ready(window_ready),
        .frame_err(frame_err)
    );

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #2000000;
        $display("FAIL global_timeout: bench did not finish in time");
        $fatal(1, "timeout");
    end

    // ---------------- scoreboard state ----------------
    logic [MW+WW-1:0] exp_q[$];
    int               hs_cyc[$];
    int               tests = 0;
    int               fails = 0;
    int               err_seen = 0;
    bit               hdr_beat = 1'b0;
    bit               err_pend = 1'b0;

    task automatic check64(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // ---------------- compare process ----------------
    always @(negedge clk) begin
        logic [WW-1:0] ew;
        logic [MW-1:0] em;
        int            bad_k;
        tests++;
        if (frame_err !== (rst ? 1'b0 : err_pend)) begin
            fails++;
            $display("FAIL frame_err: got %b expected %b (cycle %0d)", frame_err, err_pend, cyc);
        end
        if (frame_err === 1'b1) err_seen++;
        err_pend = stream_valid && stream_ready && hdr_beat &&
                   (stream[BW-1 -: 8] != 8'hA5) && !rst;

        if (rst) begin
            tests++;
            if (window_valid !== 1'b0) begin
                fails++;
                $display("FAIL reset_window_valid: got %b expected 0", window_valid);
            end
        end else if (window_valid !== 1'b0) begin
            tests++;
            if (exp_q.size() == 0) begin
                fails++;
                $display("FAIL unexpected_window: window_valid=%b meta=%0d with nothing expected (cycle %0d)",
                         window_valid, metadata, cyc);
            end else begin
                {em, ew} = exp_q[0];
                if (window !== ew || metadata !== em || window_valid !== 1'b1) begin
                    bad_k = 0;
                    for (int k = NB - 1; k >= 0; k--)
                        if (window[k*BW +: BW] !== ew[k*BW +: BW]) bad_k = k;
                    fails++;
                    $display("FAIL window_data: meta got %0d expected %0d, chunk %0d got %h expected %h (cycle %0d)",
                             metadata, em, bad_k, window[bad_k*BW +: BW], ew[bad_k*BW +: BW], cyc);
                end
                if (window_ready) begin
                    void'(exp_q.pop_front());
                    hs_cyc.push_back(cyc);
                end
            end
        end
    end

    // ---------------- driver tasks ----------------
    task automatic idle(input int n);
        stream_valid = 1'b0;
        hdr_beat     = 1'b0;
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // Holds the beat until it is accepted. The caller decides what follows.
    task automatic send_beat(input logic [BW-1:0] d, input bit hdr);
        int n;
        bit done;
        n = 0;
        done = 1'b0;
        stream       = d;
        stream_valid = 1'b1;
        hdr_beat     = hdr;
        while (!done) begin
            @(negedge clk);
            done = (stream_ready === 1'b1);
            @(posedge clk);
            #1;
            n++;
            if (!done && n > 300) begin
                tests++;
                fails++;
                $display("FAIL beat_timeout: stream_ready stayed %b for %0d cycles", stream_ready, n);
                done = 1'b1;
            end
        end
    endtask

    task automatic gap();
        int n;
        n = $urandom_range(0, 2);
        if (n > 0) idle(n);
    endtask

    function automatic logic [BW-1:0] make_hdr(input logic [MW-1:0] meta);
        logic [BW-1:0] h;
        h = {$urandom(), $urandom(), $urandom(), $urandom()};
        h[BW-1 -: 8] = 8'hA5;
        h[MW-1:0]    = meta;
        return h;
    endfunction

    task automatic send_frame(input logic [MW-1:0] meta, input logic [WW-1:0] win, input bit gappy);
        if (gappy) gap();
        send_beat(make_hdr(meta), 1'b1);
        for (int k = 0; k < NB; k++) begin
            if (gappy) gap();
            send_beat(win[k*BW +: BW], 1'b0);
        end
        exp_q.push_back({meta, win});
    endtask

    function automatic logic [WW-1:0] pattern_win();
        logic [WW-1:0] w;
        logic [7:0]    b;
        for (int k = 0; k < NB; k++) begin
            b = 8'h10 + 8'(k);
            w[k*BW +: BW] = {16{b}};
        end
        return w;
    endfunction

    function automatic logic [WW-1:0] rand_win();
        logic [WW-1:0] w;
        for (int i = 0; i < WW / 32; i++) w[i*32 +: 32] = $urandom();
        return w;
    endfunction

    task automatic do_reset();
        #1;
        rst          = 1'b1;
        stream_valid = 1'b0;
        hdr_beat     = 1'b0;
        exp_q.delete();
        repeat (2) @(posedge clk);
        @(negedge clk);
        check64("reset_stream_ready", {63'd0, stream_ready}, 64'd0);
        check64("reset_window_valid", {63'd0, window_valid}, 64'd0);
        check64("reset_window_lsb", window[63:0], 64'd0);
        check64("reset_metadata", {61'd0, metadata}, 64'd0);
        check64("reset_frame_err", {63'd0, frame_err}, 64'd0);
        @(posedge clk);
        #1;
        rst = 1'b0;
        @(negedge clk);
        check64("post_reset_stream_ready", {63'd0, stream_ready}, 64'd1);
        @(posedge clk);
        #1;
    endtask

    // ---------------- test sequence ----------------
    logic [WW-1:0] w1, w2, wb;
    int            err_before;

    initial begin
        void'($urandom(1));
        do_reset();

        // Single frame: window_valid one cycle after the last beat.
        window_ready = 1'b1;
        send_frame(3'd5, pattern_win(), 1'b0);
        stream_valid = 1'b0;
        hdr_beat     = 1'b0;
        @(negedge clk);
        check64("single_latency_valid", {63'd0, window_valid}, 64'd1);
        check64("single_byte0", {56'd0, window[7:0]}, 64'h10);
        check64("single_byte143", {56'd0, window[1151:1144]}, 64'h18);
        check64("single_meta", {61'd0, metadata}, 64'd5);
        idle(3);

        // Backpressure: first window held, second frame waits in HOLD.
        window_ready = 1'b0;
        w1 = rand_win();
        w2 = rand_win();
        send_frame(3'd1, w1, 1'b0);
        idle(3);
        @(negedge clk);
        check64("bp_held_valid", {63'd0, window_valid}, 64'd1);
        check64("bp_held_meta", {61'd0, metadata}, 64'd1);
        @(posedge clk);
        #1;
        send_frame(3'd2, w2, 1'b0);
        stream_valid = 1'b0;
        hdr_beat     = 1'b0;
        @(negedge clk);
        check64("bp_hold_stream_ready", {63'd0, stream_ready}, 64'd0);
        idle(4);
        @(negedge clk);
        check64("bp_hold_stream_ready_later", {63'd0, stream_ready}, 64'd0);
        check64("bp_still_meta1", {61'd0, metadata}, 64'd1);
        @(posedge clk);
        #1;
        window_ready = 1'b1;
        @(posedge clk);
        #1;
        @(negedge clk);
        check64("bp_release_stream_ready", {63'd0, stream_ready}, 64'd1);
        check64("bp_second_valid", {63'd0, window_valid}, 64'd1);
        check64("bp_second_meta", {61'd0, metadata}, 64'd2);
        idle(3);
        check64("bp_drained", exp_q.size(), 64'd0);

        // Back-to-back: 7 frames, windows 10 cycles apart.
        hs_cyc.delete();
        for (int f = 0; f < 7; f++) send_frame(3'(f), rand_win(), 1'b0);
        idle(4);
        check64("b2b_count", hs_cyc.size(), 64'd7);
        for (int i = 1; i < hs_cyc.size(); i++)
            check64("b2b_spacing", hs_cyc[i] - hs_cyc[i-1], 64'd10);

        // Bad header, then a good frame.
        err_before = err_seen;
        wb = {BW{1'b0}};
        wb[BW-1:BW-8] = 8'h00;
        wb[2:0] = 3'd7;
        send_beat(wb[BW-1:0], 1'b1);
        idle(3);
        check64("bad_hdr_err_pulses", err_seen - err_before, 64'd1);
        check64("bad_hdr_no_window", {63'd0, window_valid}, 64'd0);
        send_frame(3'd3, rand_win(), 1'b0);
        idle(3);

        // Gappy stream: same content as the single frame.
        send_frame(3'd5, pattern_win(), 1'b1);
        idle(3);

        // Reset mid-frame after payload beat 4.
        send_beat(make_hdr(3'd6), 1'b1);
        for (int k = 0; k < 4; k++) send_beat({4{$urandom()}}, 1'b0);
        idle(2);
        do_reset();
        check64("mid_reset_no_window", {63'd0, window_valid}, 64'd0);
        send_frame(3'd4, rand_win(), 1'b0);
        idle(4);

        check64("all_windows_delivered", exp_q.size(), 64'd0);
        check64("total_frame_err_pulses", err_seen, 64'd1);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
